// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Drives a 4-digit multiplexed common-anode 7-segment display from a 16-bit
// BCD window. A prescaler keeps each digit lit for REFRESH_DIV cycles. The
// inputs {bcd_in, neg, blank_lz} are captured once per scan frame, on the edge
// where digit0 becomes active, so an upstream shift or load in the middle of a
// frame never shows a torn value.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   bcd_in    four BCD digits, [3:0] = digit0 (rightmost) .. [15:12] = digit3
//   neg       product is negative
//   blank_lz  1 = blank leading zeros (a minus sign may take the first blank)
//   seg       segments {g,f,e,d,c,b,a}, active-low
//   an        digit anodes, active-low, an[0] = digit0
//   sign_led  captured neg, valid for the whole frame
//   frame_tk  one-cycle pulse on the cycle the capture is loaded
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        neg,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        sign_led,
    output logic        frame_tk
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // BCD to active-low gfedcba; any non-decimal nibble shows 'E'
    function automatic logic [6:0] decode_bcd(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h06;
        endcase
        return s;
    endfunction

    // ---------------- state ----------------
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       sel_reg;
    logic [15:0]      snap_bcd_reg;
    logic             snap_neg_reg;
    logic             snap_blank_reg;
    logic [6:0]       seg_reg;
    logic [3:0]       an_reg;
    logic             frame_tk_reg;

    // ---------------- control ----------------
    logic       tick;
    logic       frame_load;
    logic [1:0] sel_next;

    assign tick       = (cnt_reg == CNT_MAX);
    // sel==3 is both the last digit and the idle pre-frame state after reset
    assign frame_load = tick && (sel_reg == 2'd3);
    assign sel_next   = (sel_reg == 2'd3) ? 2'd0 : sel_reg + 2'd1;

    // Values in effect for the slot being entered: on a frame load digit0
    // must use what is captured at that very edge, so bypass the snapshot.
    logic [15:0] eff_bcd;
    logic        eff_neg;
    logic        eff_blank;

    assign eff_bcd   = frame_load ? bcd_in   : snap_bcd_reg;
    assign eff_neg   = frame_load ? neg      : snap_neg_reg;
    assign eff_blank = frame_load ? blank_lz : snap_blank_reg;

    // ---------------- per-digit decode ----------------
    logic [3:1] nz;          // nibble i is non-zero (invalid nibbles count)
    logic [3:1] lead_zero;   // nibbles i..3 are all zero
    logic [1:0] msd_idx;     // highest non-zero digit, 0 when all zero
    logic [2:0] minus_idx;   // digit that carries the minus sign
    logic [6:0] dig_seg [4];
    logic [3:0] dig_on;

    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_nz
            assign nz[gi]        = (eff_bcd[4*gi +: 4] != 4'd0);
            assign lead_zero[gi] = ~|nz[3:gi];
        end
    endgenerate

    assign msd_idx   = nz[3] ? 2'd3 : nz[2] ? 2'd2 : nz[1] ? 2'd1 : 2'd0;
    assign minus_idx = {1'b0, msd_idx} + 3'd1;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                // digit0 is never blanked
                assign dig_on[gi]  = 1'b1;
                assign dig_seg[gi] = decode_bcd(eff_bcd[3:0]);
            end else begin : g_upper
                logic is_blank;
                logic is_minus;
                assign is_blank = eff_blank && lead_zero[gi];
                // A minus only ever replaces the first blanked position, so
                // with msd_idx==3 (minus_idx==4) it is never drawn.
                assign is_minus = is_blank && eff_neg && (minus_idx == 3'(gi));
                assign dig_on[gi]  = !is_blank || is_minus;
                assign dig_seg[gi] = is_minus ? SEG_MINUS :
                                     is_blank ? SEG_BLANK :
                                     decode_bcd(eff_bcd[4*gi +: 4]);
            end
        end
    endgenerate

    logic [6:0] seg_next;
    logic [3:0] an_next;

    always_comb begin
        seg_next = dig_seg[sel_next];
        an_next  = 4'b1111;
        if (dig_on[sel_next]) begin
            an_next = ~(4'b0001 << sel_next);
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            sel_reg        <= 2'd3;
            snap_bcd_reg   <= 16'h0000;
            snap_neg_reg   <= 1'b0;
            snap_blank_reg <= 1'b0;
            seg_reg        <= SEG_BLANK;
            an_reg         <= 4'b1111;
            frame_tk_reg   <= 1'b0;
        end else begin
            cnt_reg      <= tick ? '0 : cnt_reg + CNT_W'(1);
            frame_tk_reg <= frame_load;
            if (tick) begin
                sel_reg <= sel_next;
                seg_reg <= seg_next;
                an_reg  <= an_next;
            end
            if (frame_load) begin
                snap_bcd_reg   <= bcd_in;
                snap_neg_reg   <= neg;
                snap_blank_reg <= blank_lz;
            end
        end
    end

    assign seg      = seg_reg;
    assign an       = an_reg;
    assign sign_led = snap_neg_reg;
    assign frame_tk = frame_tk_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic        neg;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        sign_led;
    logic        frame_tk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       ftk;
        logic       sled;
    } exp_t;

    exp_t sb[$];

    seven_seg_scanner #(.REFRESH_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd_in   (bcd_in),
        .neg      (neg),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .sign_led (sign_led),
        .frame_tk (frame_tk)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic f, input logic l);
        exp_t e;
        e.an = a; e.seg = s; e.ftk = f; e.sled = l;
        sb.push_back(e);
    endtask

    // Called just after the edge that starts a digit slot; checks the slot
    // start against the scoreboard, that it holds, then moves to the next slot.
    task automatic run_slot(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            $display("slot %s: an=%b seg=%h frame_tk=%b sign_led=%b (exp an=%b seg=%h)",
                     tag, an, seg, frame_tk, sign_led, e.an, e.seg);
            chk({tag, "_an"},   {4'd0, an},       {4'd0, e.an});
            chk({tag, "_seg"},  {1'b0, seg},      {1'b0, e.seg});
            chk({tag, "_ftk"},  {7'd0, frame_tk}, {7'd0, e.ftk});
            chk({tag, "_sled"}, {7'd0, sign_led}, {7'd0, e.sled});
            for (int i = 0; i < 3; i++) begin
                step();
                chk({tag, "_hold_an"},  {4'd0, an},       {4'd0, e.an});
                chk({tag, "_hold_seg"}, {1'b0, seg},      {1'b0, e.seg});
                chk({tag, "_hold_ftk"}, {7'd0, frame_tk}, 8'd0);
            end
        end
        step();
    endtask

    // Runs a full frame; new inputs are applied during the digit1 slot and
    // must only appear in the following frame.
    task automatic run_frame(input string tag, input logic [15:0] nb, input logic nn, input logic nbl);
        run_slot({tag, "_d0"});
        bcd_in = nb; neg = nn; blank_lz = nbl;
        run_slot({tag, "_d1"});
        run_slot({tag, "_d2"});
        run_slot({tag, "_d3"});
    endtask

    initial begin
        int n;
        rst = 1'b1; bcd_in = 16'h0000; neg = 1'b0; blank_lz = 1'b0;
        repeat (3) step();
        chk("rst_an",   {4'd0, an},       8'h0F);
        chk("rst_seg",  {1'b0, seg},      8'h7F);
        chk("rst_ftk",  {7'd0, frame_tk}, 8'd0);
        chk("rst_sled", {7'd0, sign_led}, 8'd0);

        // Release reset; idle for 3 cycles, frame starts on the 4th
        bcd_in = 16'h1234; neg = 1'b0; blank_lz = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_an",  {4'd0, an},       8'h0F);
            chk("idle_seg", {1'b0, seg},      8'h7F);
            chk("idle_ftk", {7'd0, frame_tk}, 8'd0);
        end
        step();

        // 1234, no blanking
        push(4'b1110, 7'h19, 1'b1, 1'b0);
        push(4'b1101, 7'h30, 1'b0, 1'b0);
        push(4'b1011, 7'h24, 1'b0, 1'b0);
        push(4'b0111, 7'h79, 1'b0, 1'b0);
        run_frame("f1234a", 16'h1234, 1'b0, 1'b0);

        // Repeat of 1234; input changes to 5678 in the digit1 slot
        push(4'b1110, 7'h19, 1'b1, 1'b0);
        push(4'b1101, 7'h30, 1'b0, 1'b0);
        push(4'b1011, 7'h24, 1'b0, 1'b0);
        push(4'b0111, 7'h79, 1'b0, 1'b0);
        run_frame("f1234b", 16'h5678, 1'b0, 1'b0);

        push(4'b1110, 7'h00, 1'b1, 1'b0);
        push(4'b1101, 7'h78, 1'b0, 1'b0);
        push(4'b1011, 7'h02, 1'b0, 1'b0);
        push(4'b0111, 7'h12, 1'b0, 1'b0);
        run_frame("f5678", 16'h0007, 1'b1, 1'b1);

        // 0007, blank, negative: minus in digit1
        push(4'b1110, 7'h78, 1'b1, 1'b1);
        push(4'b1101, 7'h3F, 1'b0, 1'b1);
        push(4'b1111, 7'h7F, 1'b0, 1'b1);
        push(4'b1111, 7'h7F, 1'b0, 1'b1);
        run_frame("f0007n", 16'h00A0, 1'b0, 1'b1);

        // 00A0, blank: invalid nibble shows E and counts as non-zero
        push(4'b1110, 7'h40, 1'b1, 1'b0);
        push(4'b1101, 7'h06, 1'b0, 1'b0);
        push(4'b1111, 7'h7F, 1'b0, 1'b0);
        push(4'b1111, 7'h7F, 1'b0, 1'b0);
        run_frame("f00A0", 16'h1000, 1'b1, 1'b1);

        // 1000, blank, negative: inner zeros shown, no room for minus
        push(4'b1110, 7'h40, 1'b1, 1'b1);
        push(4'b1101, 7'h40, 1'b0, 1'b1);
        push(4'b1011, 7'h40, 1'b0, 1'b1);
        push(4'b0111, 7'h79, 1'b0, 1'b1);
        run_frame("f1000n", 16'h0000, 1'b1, 1'b1);

        // 0000, blank, negative: digit0 zero, minus in digit1
        push(4'b1110, 7'h40, 1'b1, 1'b1);
        push(4'b1101, 7'h3F, 1'b0, 1'b1);
        push(4'b1111, 7'h7F, 1'b0, 1'b1);
        push(4'b1111, 7'h7F, 1'b0, 1'b1);
        run_frame("f0000n", 16'h1234, 1'b0, 1'b0);

        // 1234 frame interrupted by reset during the digit2 slot
        push(4'b1110, 7'h19, 1'b1, 1'b0);
        push(4'b1101, 7'h30, 1'b0, 1'b0);
        run_slot("frst_d0");
        run_slot("frst_d1");
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_an",   {4'd0, an},       8'h0F);
        chk("mid_rst_seg",  {1'b0, seg},      8'h7F);
        chk("mid_rst_ftk",  {7'd0, frame_tk}, 8'd0);
        chk("mid_rst_sled", {7'd0, sign_led}, 8'd0);

        n = 0;
        do begin
            step();
            n++;
        end while (frame_tk !== 1'b1 && n < 20);
        chk("rst_frame_delay", 8'(n), 8'd4);

        push(4'b1110, 7'h19, 1'b1, 1'b0);
        run_slot("fpost_d0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
